lsu_queue: RTL and testbench
============================

Name: lsu_queue

Overview:
- Parametrised successor to the single-entry load/store unit. Accepts memory ops through a valid/ready port into a DEPTH-entry in-order queue.
- Issues one blocking data-memory access at a time with byte masks and store-data alignment, then returns a tagged writeback that carries load extraction and sign extension.
- Misaligned or illegal ops complete as exceptions without any memory access. flush_i discards all queued work, and a response still in flight is drained safely.

Parameters:
DEPTH, 4, number of queue entries; power of two, at least 2
TAG_W, 5, width of the ROB/instruction tag carried with each op

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
req_valid_i  in  1  op offered
req_ready_o  out  1  op accepted when high together with req_valid_i
req_load_i  in  1  1=load, 0=store
req_funct3_i  in  3  RV32I load/store funct3
req_addr_i  in  32  byte address
req_wdata_i  in  32  store data, unaligned (low bits)
req_rd_i  in  5  destination register
req_tag_i  in  TAG_W  op tag
flush_i  in  1  discard queue and in-flight result
dmem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
dmem_rmask_o  out  4  load byte mask
dmem_wmask_o  out  4  store byte mask
dmem_wdata_o  out  32  store data shifted to byte lane
dmem_resp_i  in  1  access complete (one-cycle pulse)
dmem_rdata_i  in  32  load data word, valid with dmem_resp_i
wb_valid_o  out  1  one-cycle completion pulse
wb_tag_o  out  TAG_W  tag of completed op
wb_rd_o  out  5  destination register
wb_rd_wr_o  out  1  register write enable
wb_data_o  out  32  extracted load value
wb_exc_o  out  1  misaligned/illegal op
busy_o  out  1  queue non-empty or state!=IDLE

Behaviour:
- Reset: clears the queue and sets state IDLE. All outputs are 0 except req_ready_o=1.
- Enqueue: push when req_valid_i && req_ready_o. req_ready_o = (count<DEPTH) && !flush_i. A full queue does not accept, even if a pop happens in the same cycle. Push and pop in the same cycle are legal and leave count unchanged. Pointers wrap modulo DEPTH.
- Illegal/misaligned check (evaluated at the head):
  - Load funct3 in {3,6,7} or store funct3 > 2 is illegal.
  - lh/lhu/sh with addr[0]=1 is misaligned.
  - lw/sw with addr[1:0]!=0 is misaligned.
- State IDLE: if the queue is non-empty:
  - Head is illegal/misaligned: pop it and pulse wb_valid_o next cycle with wb_exc_o=1, wb_rd_wr_o=0, wb_data_o=0. Stay in IDLE.
  - Otherwise: register the dmem outputs and go to WAIT.
- dmem masks:
  - Byte: 4'b0001<<a. Half: 4'b0011<<a. Word: 4'b1111 (a = addr[1:0]).
  - Loads drive only rmask; stores drive only wmask.
  - dmem_wdata_o = wdata<<(8*a).
- State WAIT: the dmem outputs are held stable, and masks are non-zero only in WAIT/DRAIN.
  - On dmem_resp_i: pop the head, zero the masks, go to IDLE, and pulse wb_valid_o on the next cycle.
  - Load writeback: wb_data_o = byte/half/word selected from dmem_rdata_i by a, sign- or zero-extended per funct3. wb_rd_wr_o = (rd!=0).
  - Store writeback: wb_rd_wr_o=0 and wb_data_o=0.
- Latency: push to an empty queue at cycle N gives WAIT at N+1. A response at cycle M gives wb_valid_o at M+1. A misaligned op at the head completes 1 cycle after reaching the head.
- flush_i:
  - Count goes to 0 next cycle. No wb_valid_o is produced for any op popped or responded in the flush cycle or later.
  - In WAIT without dmem_resp_i: go to DRAIN. DRAIN holds the dmem outputs until dmem_resp_i, discards the data, then returns to IDLE.
  - In WAIT with dmem_resp_i in the same cycle: go to IDLE and suppress wb_valid_o.
  - In DRAIN, new ops may enqueue but are not issued until IDLE.
- wb_* outputs are registered and return to 0 the cycle after the pulse.
- Reset asserted mid-operation aborts immediately to the reset state. Any dmem transaction then outstanding is abandoned.

Test Plan:
- lb addr=0x1003, rdata=0x80FF_1234, resp after 3 cycles -> dmem_addr_o=0x1000, rmask=4'b1000; wb_data_o=0xFFFF_FF80 at resp+1; wb_rd_wr_o=1.
- sh addr=0x2002, wdata=0x0000_BEEF -> wmask=4'b1100, dmem_wdata_o=0xBEEF_0000; wb_valid_o with wb_rd_wr_o=0.
- lw addr=0x3001 tag=7 -> no mask ever asserted; wb_valid_o 1 cycle after reaching head; wb_exc_o=1, wb_tag_o=7.
- Push 4 ops with resp held off -> req_ready_o=0 after the 4th. Ops complete in order with tags 0..3, one wb pulse per resp.
- flush_i in WAIT with 2 ops queued -> DRAIN holds masks until resp; no wb_valid_o; busy_o=0 the cycle after returning to IDLE.
- Flush in the same cycle as dmem_resp_i -> no wb_valid_o; a subsequent lhu addr=0x2 with rdata=0x8001_0000 -> wb_data_o=0x0000_8001.

Source files
------------

// File: rtl/lsu_queue.sv
// In-order load/store queue: buffers DEPTH ops, issues one blocking data-memory
// access at a time and returns a tagged writeback with load extraction.
module lsu_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_load_i,
    input  logic [2:0]       req_funct3_i,
    input  logic [31:0]      req_addr_i,
    input  logic [31:0]      req_wdata_i,
    input  logic [4:0]       req_rd_i,
    input  logic [TAG_W-1:0] req_tag_i,
    input  logic             flush_i,
    output logic [31:0]      dmem_addr_o,
    output logic [3:0]       dmem_rmask_o,
    output logic [3:0]       dmem_wmask_o,
    output logic [31:0]      dmem_wdata_o,
    input  logic             dmem_resp_i,
    input  logic [31:0]      dmem_rdata_i,
    output logic             wb_valid_o,
    output logic [TAG_W-1:0] wb_tag_o,
    output logic [4:0]       wb_rd_o,
    output logic             wb_rd_wr_o,
    output logic [31:0]      wb_data_o,
    output logic             wb_exc_o,
    output logic             busy_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DRAIN
    } state_t;

    typedef struct packed {
        logic             load;
        logic [2:0]       funct3;
        logic [31:0]      addr;
        logic [31:0]      wdata;
        logic [4:0]       rd;
        logic [TAG_W-1:0] tag;
    } entry_t;

    state_t           state, state_nxt;
    entry_t           q [DEPTH];
    entry_t           req_e, head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             empty, push, pop, head_valid;
    logic             issue, retire, wb_fire, exc_fire;
    logic [1:0]       head_a;
    logic             head_illegal, head_misal, head_bad;
    logic [3:0]       head_mask;

    logic             cur_load;
    logic [2:0]       cur_funct3;
    logic [1:0]       cur_a;
    logic [4:0]       cur_rd;
    logic [TAG_W-1:0] cur_tag;
    logic [31:0]      rdata_sh, load_val;

    assign empty       = (count == '0);
    assign req_ready_o = (count < CNT_W'(DEPTH)) && !flush_i;
    assign push        = req_valid_i && req_ready_o;
    assign busy_o      = !empty || (state != ST_IDLE);

    assign req_e = '{load:   req_load_i,
                     funct3: req_funct3_i,
                     addr:   req_addr_i,
                     wdata:  req_wdata_i,
                     rd:     req_rd_i,
                     tag:    req_tag_i};

    // An op pushed into an empty queue is its own head, so it can issue in the push cycle.
    assign head       = empty ? req_e : q[rd_ptr];
    assign head_valid = !empty || push;

    always_comb begin
        head_a       = head.addr[1:0];
        head_illegal = head.load ? ((head.funct3[1:0] == 2'b11) || (head.funct3 == 3'd6))
                                 : (head.funct3 > 3'd2);
        head_misal   = ((head.funct3[1:0] == 2'b01) && head_a[0]) ||
                       ((head.funct3[1:0] == 2'b10) && (head_a != 2'b00));
        head_bad     = head_illegal || head_misal;
        case (head.funct3[1:0])
            2'b00:   head_mask = 4'b0001 << head_a;
            2'b01:   head_mask = 4'b0011 << head_a;
            default: head_mask = 4'b1111;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        retire    = 1'b0;
        pop       = 1'b0;
        wb_fire   = 1'b0;
        exc_fire  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!flush_i && head_valid) begin
                    if (head_bad) begin
                        pop      = 1'b1;
                        wb_fire  = 1'b1;
                        exc_fire = 1'b1;
                    end else begin
                        issue     = 1'b1;
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (dmem_resp_i) begin
                    retire    = 1'b1;
                    state_nxt = ST_IDLE;
                    if (!flush_i) begin
                        pop     = 1'b1;
                        wb_fire = 1'b1;
                    end
                end else if (flush_i) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (dmem_resp_i) begin
                    retire    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) q[wr_ptr] <= req_e;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dmem_addr_o  <= '0;
            dmem_rmask_o <= '0;
            dmem_wmask_o <= '0;
            dmem_wdata_o <= '0;
            cur_load     <= 1'b0;
            cur_funct3   <= '0;
            cur_a        <= '0;
            cur_rd       <= '0;
            cur_tag      <= '0;
        end else if (issue) begin
            dmem_addr_o  <= {head.addr[31:2], 2'b00};
            dmem_rmask_o <= head.load ? head_mask : 4'b0000;
            dmem_wmask_o <= head.load ? 4'b0000 : head_mask;
            dmem_wdata_o <= head.wdata << {head_a, 3'b000};
            cur_load     <= head.load;
            cur_funct3   <= head.funct3;
            cur_a        <= head_a;
            cur_rd       <= head.rd;
            cur_tag      <= head.tag;
        end else if (retire) begin
            dmem_rmask_o <= '0;
            dmem_wmask_o <= '0;
        end
    end

    assign rdata_sh = dmem_rdata_i >> {cur_a, 3'b000};

    always_comb begin
        case (cur_funct3[1:0])
            2'b00:   load_val = {{24{!cur_funct3[2] && rdata_sh[7]}}, rdata_sh[7:0]};
            2'b01:   load_val = {{16{!cur_funct3[2] && rdata_sh[15]}}, rdata_sh[15:0]};
            default: load_val = dmem_rdata_i;
        endcase
    end

    // Writeback fields are zero outside the one-cycle pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_valid_o <= 1'b0;
            wb_tag_o   <= '0;
            wb_rd_o    <= '0;
            wb_rd_wr_o <= 1'b0;
            wb_data_o  <= '0;
            wb_exc_o   <= 1'b0;
        end else begin
            wb_valid_o <= wb_fire;
            wb_exc_o   <= exc_fire;
            if (exc_fire) begin
                wb_tag_o   <= head.tag;
                wb_rd_o    <= head.rd;
                wb_rd_wr_o <= 1'b0;
                wb_data_o  <= '0;
            end else if (wb_fire) begin
                wb_tag_o   <= cur_tag;
                wb_rd_o    <= cur_rd;
                wb_rd_wr_o <= cur_load && (cur_rd != 5'd0);
                wb_data_o  <= cur_load ? load_val : 32'd0;
            end else begin
                wb_tag_o   <= '0;
                wb_rd_o    <= '0;
                wb_rd_wr_o <= 1'b0;
                wb_data_o  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_queue.sv
// Directed bench for lsu_queue: one task per scenario with hand-computed expectations.
module tb_lsu_queue;

    localparam int TAG_W = 5;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             req_valid_i;
    logic             req_ready_o;
    logic             req_load_i;
    logic [2:0]       req_funct3_i;
    logic [31:0]      req_addr_i;
    logic [31:0]      req_wdata_i;
    logic [4:0]       req_rd_i;
    logic [TAG_W-1:0] req_tag_i;
    logic             flush_i;
    logic [31:0]      dmem_addr_o;
    logic [3:0]       dmem_rmask_o;
    logic [3:0]       dmem_wmask_o;
    logic [31:0]      dmem_wdata_o;
    logic             dmem_resp_i;
    logic [31:0]      dmem_rdata_i;
    logic             wb_valid_o;
    logic [TAG_W-1:0] wb_tag_o;
    logic [4:0]       wb_rd_o;
    logic             wb_rd_wr_o;
    logic [31:0]      wb_data_o;
    logic             wb_exc_o;
    logic             busy_o;

    int vecs = 0;
    int errs = 0;

    lsu_queue #(.DEPTH(4), .TAG_W(TAG_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_load_i(req_load_i), .req_funct3_i(req_funct3_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_rd_i(req_rd_i), .req_tag_i(req_tag_i),
        .flush_i(flush_i),
        .dmem_addr_o(dmem_addr_o), .dmem_rmask_o(dmem_rmask_o),
        .dmem_wmask_o(dmem_wmask_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_resp_i(dmem_resp_i), .dmem_rdata_i(dmem_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_tag_o(wb_tag_o), .wb_rd_o(wb_rd_o),
        .wb_rd_wr_o(wb_rd_wr_o), .wb_data_o(wb_data_o), .wb_exc_o(wb_exc_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    task automatic nxt;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_req(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [4:0] rd,
                             input logic [TAG_W-1:0] tag);
        req_valid_i  = 1'b1;
        req_load_i   = ld;
        req_funct3_i = f3;
        req_addr_i   = addr;
        req_wdata_i  = wdata;
        req_rd_i     = rd;
        req_tag_i    = tag;
    endtask

    task automatic idle_req;
        req_valid_i  = 1'b0;
        req_load_i   = 1'b0;
        req_funct3_i = 3'd0;
        req_addr_i   = 32'd0;
        req_wdata_i  = 32'd0;
        req_rd_i     = 5'd0;
        req_tag_i    = '0;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        idle_req();
        flush_i      = 1'b0;
        dmem_resp_i  = 1'b0;
        dmem_rdata_i = 32'd0;
        #2;
        vecs++; if (req_ready_o !== 1'b1) begin errs++; $display("FAIL rst_ready: got %b want 1", req_ready_o); end
        vecs++; if (busy_o !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b want 0", busy_o); end
        vecs++; if ({dmem_rmask_o, dmem_wmask_o} !== 8'h00) begin errs++; $display("FAIL rst_masks: got %h want 00", {dmem_rmask_o, dmem_wmask_o}); end
        vecs++; if (dmem_addr_o !== 32'd0 || dmem_wdata_o !== 32'd0) begin errs++; $display("FAIL rst_dmem: got %h/%h want 0/0", dmem_addr_o, dmem_wdata_o); end
        vecs++; if ({wb_valid_o, wb_exc_o, wb_rd_wr_o} !== 3'b000 || wb_data_o !== 32'd0 || wb_tag_o !== '0 || wb_rd_o !== 5'd0) begin
            errs++; $display("FAIL rst_wb: got valid=%b data=%h want all zero", wb_valid_o, wb_data_o); end
        nxt(); nxt();
        rst_i = 1'b0;
        nxt();
    endtask

    task automatic test_lb_sign;
        drive_req(1'b1, 3'd0, 32'h0000_1003, 32'd0, 5'd5, 5'd1);
        #1;
        vecs++; if (req_ready_o !== 1'b1) begin errs++; $display("FAIL lb_ready: got %b want 1", req_ready_o); end
        nxt();
        idle_req();
        #1;
        vecs++; if (dmem_addr_o !== 32'h0000_1000) begin errs++; $display("FAIL lb_addr: got %h want 00001000", dmem_addr_o); end
        vecs++; if (dmem_rmask_o !== 4'b1000 || dmem_wmask_o !== 4'b0000) begin errs++; $display("FAIL lb_mask: got r=%b w=%b want r=1000 w=0000", dmem_rmask_o, dmem_wmask_o); end
        for (int i = 0; i < 2; i++) begin
            nxt();
            vecs++; if (dmem_rmask_o !== 4'b1000) begin errs++; $display("FAIL lb_hold: got %b want 1000", dmem_rmask_o); end
        end
        nxt();
        dmem_resp_i  = 1'b1;
        dmem_rdata_i = 32'h80FF_1234;
        #1;
        vecs++; if (wb_valid_o !== 1'b0) begin errs++; $display("FAIL lb_early_wb: got %b want 0", wb_valid_o); end
        nxt();
        dmem_resp_i  = 1'b0;
        dmem_rdata_i = 32'd0;
        #1;
        vecs++; if (wb_valid_o !== 1'b1 || wb_exc_o !== 1'b0) begin errs++; $display("FAIL lb_wb: got valid=%b exc=%b want 1/0", wb_valid_o, wb_exc_o); end
        vecs++; if (wb_data_o !== 32'hFFFF_FF80) begin errs++; $display("FAIL lb_data: got %h want ffffff80", wb_data_o); end
        vecs++; if (wb_rd_wr_o !== 1'b1 || wb_rd_o !== 5'd5 || wb_tag_o !== 5'd1) begin errs++; $display("FAIL lb_fields: got wr=%b rd=%0d tag=%0d want 1/5/1", wb_rd_wr_o, wb_rd_o, wb_tag_o); end
        vecs++; if (dmem_rmask_o !== 4'b0000) begin errs++; $display("FAIL lb_mask_clr: got %b want 0000", dmem_rmask_o); end
        nxt();
        vecs++; if (wb_valid_o !== 1'b0 || wb_data_o !== 32'd0) begin errs++; $display("FAIL lb_wb_clr: got valid=%b data=%h want 0/0", wb_valid_o, wb_data_o); end
        vecs++; if (busy_o !== 1'b0) begin errs++; $display("FAIL lb_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_stores;
        drive_req(1'b0, 3'd1, 32'h0000_2002, 32'h0000_BEEF, 5'd3, 5'd2);
        nxt();
        idle_req();
        #1;
        vecs++; if (dmem_wmask_o !== 4'b1100 || dmem_rmask_o !== 4'b0000) begin errs++; $display("FAIL sh_mask: got w=%b r=%b want w=1100 r=0000", dmem_wmask_o, dmem_rmask_o); end
        vecs++; if (dmem_wdata_o !== 32'hBEEF_0000) begin errs++; $display("FAIL sh_wdata: got %h want beef0000", dmem_wdata_o); end
        vecs++; if (dmem_addr_o !== 32'h0000_2000) begin errs++; $display("FAIL sh_addr: got %h want 00002000", dmem_addr_o); end
        dmem_resp_i = 1'b1;
        nxt();
        dmem_resp_i = 1'b0;
        #1;
        vecs++; if (wb_valid_o !== 1'b1 || wb_rd_wr_o !== 1'b0 || wb_data_o !== 32'd0 || wb_tag_o !== 5'd2) begin
            errs++; $display("FAIL sh_wb: got v=%b wr=%b d=%h tag=%0d want 1/0/0/2", wb_valid_o, wb_rd_wr_o, wb_data_o, wb_tag_o); end
        nxt();
        drive_req(1'b0, 3'd0, 32'h0000_0041, 32'h1234_56AB, 5'd0, 5'd3);
        nxt();
        idle_req();
        #1;
        vecs++; if (dmem_wmask_o !== 4'b0010 || dmem_wdata_o !== 32'h3456_AB00) begin errs++; $display("FAIL sb_lane: got w=%b d=%h want 0010/3456ab00", dmem_wmask_o, dmem_wdata_o); end
        dmem_resp_i = 1'b1;
        nxt();
        dmem_resp_i = 1'b0;
        nxt();
    endtask

    task automatic test_exceptions;
        drive_req(1'b1, 3'd2, 32'h0000_3001, 32'd0, 5'd9, 5'd7);
        #1;
        vecs++; if ({dmem_rmask_o, dmem_wmask_o} !== 8'h00) begin errs++; $display("FAIL lw_mis_mask0: got %h want 00", {dmem_rmask_o, dmem_wmask_o}); end
        nxt();
        idle_req();
        #1;
        vecs++; if (wb_valid_o !== 1'b1 || wb_exc_o !== 1'b1 || wb_tag_o !== 5'd7) begin errs++; $display("FAIL lw_mis_wb: got v=%b exc=%b tag=%0d want 1/1/7", wb_valid_o, wb_exc_o, wb_tag_o); end
        vecs++; if (wb_rd_wr_o !== 1'b0 || wb_data_o !== 32'd0) begin errs++; $display("FAIL lw_mis_fields: got wr=%b d=%h want 0/0", wb_rd_wr_o, wb_data_o); end
        vecs++; if ({dmem_rmask_o, dmem_wmask_o} !== 8'h00) begin errs++; $display("FAIL lw_mis_mask1: got %h want 00", {dmem_rmask_o, dmem_wmask_o}); end
        nxt();
        vecs++; if (wb_valid_o !== 1'b0 || wb_exc_o !== 1'b0 || busy_o !== 1'b0) begin errs++; $display("FAIL lw_mis_after: got v=%b exc=%b busy=%b want 0/0/0", wb_valid_o, wb_exc_o, busy_o); end
        drive_req(1'b0, 3'd3, 32'h0000_0010, 32'd0, 5'd0, 5'd4);
        nxt();
        idle_req();
        #1;
        vecs++; if (wb_valid_o !== 1'b1 || wb_exc_o !== 1'b1 || wb_tag_o !== 5'd4 || dmem_wmask_o !== 4'b0000) begin
            errs++; $display("FAIL st_illegal: got v=%b exc=%b tag=%0d wm=%b want 1/1/4/0000", wb_valid_o, wb_exc_o, wb_tag_o, dmem_wmask_o); end
        drive_req(1'b1, 3'd5, 32'h0000_0021, 32'd0, 5'd2, 5'd6);
        nxt();
        idle_req();
        #1;
        vecs++; if (wb_valid_o !== 1'b1 || wb_exc_o !== 1'b1 || wb_tag_o !== 5'd6 || dmem_rmask_o !== 4'b0000) begin
            errs++; $display("FAIL lhu_mis: got v=%b exc=%b tag=%0d rm=%b want 1/1/6/0000", wb_valid_o, wb_exc_o, wb_tag_o, dmem_rmask_o); end
        nxt();
    endtask

    task automatic test_full_in_order;
        for (int i = 0; i < 4; i++) begin
            drive_req(1'b1, 3'd2, 32'h100 + 32'(4 * i), 32'd0, 5'(i), 5'(i));
            #1;
            vecs++; if (req_ready_o !== 1'b1) begin errs++; $display("FAIL full_ready%0d: got %b want 1", i, req_ready_o); end
            nxt();
        end
        drive_req(1'b1, 3'd2, 32'h200, 32'd0, 5'd1, 5'd9);
        #1;
        vecs++; if (req_ready_o !== 1'b0) begin errs++; $display("FAIL full_ready_low: got %b want 0", req_ready_o); end
        idle_req();
        for (int i = 0; i < 4; i++) begin
            vecs++; if (dmem_addr_o !== 32'h100 + 32'(4 * i) || dmem_rmask_o !== 4'b1111) begin
                errs++; $display("FAIL full_issue%0d: got a=%h m=%b want %h/1111", i, dmem_addr_o, dmem_rmask_o, 32'h100 + 32'(4 * i)); end
            dmem_resp_i  = 1'b1;
            dmem_rdata_i = 32'hA000_0000 + 32'(i);
            nxt();
            dmem_resp_i  = 1'b0;
            dmem_rdata_i = 32'd0;
            #1;
            vecs++; if (wb_valid_o !== 1'b1 || wb_tag_o !== 5'(i) || wb_data_o !== 32'hA000_0000 + 32'(i)) begin
                errs++; $display("FAIL full_wb%0d: got v=%b tag=%0d d=%h want 1/%0d/%h", i, wb_valid_o, wb_tag_o, wb_data_o, i, 32'hA000_0000 + 32'(i)); end
            vecs++; if (wb_rd_wr_o !== (i != 0)) begin errs++; $display("FAIL full_rdwr%0d: got %b want %b", i, wb_rd_wr_o, (i != 0)); end
            nxt();
            vecs++; if (wb_valid_o !== 1'b0) begin errs++; $display("FAIL full_single%0d: got %b want 0", i, wb_valid_o); end
        end
        vecs++; if (busy_o !== 1'b0) begin errs++; $display("FAIL full_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_flush_drain;
        for (int i = 0; i < 3; i++) begin
            drive_req(1'b1, 3'd2, 32'h400 + 32'(4 * i), 32'd0, 5'd1, 5'(10 + i));
            nxt();
        end
        idle_req();
        flush_i = 1'b1;
        #1;
        vecs++; if (req_ready_o !== 1'b0) begin errs++; $display("FAIL flush_ready: got %b want 0", req_ready_o); end
        nxt();
        flush_i = 1'b0;
        #1;
        vecs++; if (dmem_rmask_o !== 4'b1111 || dmem_addr_o !== 32'h400 || busy_o !== 1'b1) begin
            errs++; $display("FAIL drain_hold: got m=%b a=%h busy=%b want 1111/400/1", dmem_rmask_o, dmem_addr_o, busy_o); end
        vecs++; if (req_ready_o !== 1'b1) begin errs++; $display("FAIL drain_ready: got %b want 1", req_ready_o); end
        nxt();
        vecs++; if (dmem_rmask_o !== 4'b1111 || wb_valid_o !== 1'b0) begin errs++; $display("FAIL drain_hold2: got m=%b v=%b want 1111/0", dmem_rmask_o, wb_valid_o); end
        dmem_resp_i  = 1'b1;
        dmem_rdata_i = 32'hDEAD_BEEF;
        nxt();
        dmem_resp_i  = 1'b0;
        dmem_rdata_i = 32'd0;
        #1;
        vecs++; if (wb_valid_o !== 1'b0 || dmem_rmask_o !== 4'b0000 || busy_o !== 1'b0) begin
            errs++; $display("FAIL drain_exit: got v=%b m=%b busy=%b want 0/0000/0", wb_valid_o, dmem_rmask_o, busy_o); end
        nxt();
        vecs++; if (wb_valid_o !== 1'b0 || dmem_rmask_o !== 4'b0000) begin errs++; $display("FAIL flush_discard: got v=%b m=%b want 0/0000", wb_valid_o, dmem_rmask_o); end
    endtask

    task automatic test_flush_with_resp;
        drive_req(1'b1, 3'd2, 32'h600, 32'd0, 5'd4, 5'd20);
        nxt();
        idle_req();
        dmem_resp_i  = 1'b1;
        dmem_rdata_i = 32'h1111_2222;
        flush_i      = 1'b1;
        nxt();
        dmem_resp_i  = 1'b0;
        dmem_rdata_i = 32'd0;
        flush_i      = 1'b0;
        #1;
        vecs++; if (wb_valid_o !== 1'b0 || busy_o !== 1'b0 || dmem_rmask_o !== 4'b0000) begin
            errs++; $display("FAIL flush_resp: got v=%b busy=%b m=%b want 0/0/0000", wb_valid_o, busy_o, dmem_rmask_o); end
        drive_req(1'b1, 3'd5, 32'h0000_0002, 32'd0, 5'd7, 5'd21);
        nxt();
        idle_req();
        #1;
        vecs++; if (dmem_rmask_o !== 4'b1100 || dmem_addr_o !== 32'd0) begin errs++; $display("FAIL lhu_issue: got m=%b a=%h want 1100/0", dmem_rmask_o, dmem_addr_o); end
        dmem_resp_i  = 1'b1;
        dmem_rdata_i = 32'h8001_0000;
        nxt();
        dmem_resp_i  = 1'b0;
        dmem_rdata_i = 32'd0;
        #1;
        vecs++; if (wb_valid_o !== 1'b1 || wb_data_o !== 32'h0000_8001 || wb_rd_wr_o !== 1'b1 || wb_tag_o !== 5'd21) begin
            errs++; $display("FAIL lhu_wb: got v=%b d=%h wr=%b tag=%0d want 1/00008001/1/21", wb_valid_o, wb_data_o, wb_rd_wr_o, wb_tag_o); end
        nxt();
        drive_req(1'b1, 3'd1, 32'h0000_0000, 32'd0, 5'd8, 5'd22);
        nxt();
        idle_req();
        dmem_resp_i  = 1'b1;
        dmem_rdata_i = 32'h0000_F00D;
        nxt();
        dmem_resp_i  = 1'b0;
        dmem_rdata_i = 32'd0;
        #1;
        vecs++; if (wb_valid_o !== 1'b1 || wb_data_o !== 32'hFFFF_F00D) begin errs++; $display("FAIL lh_sign: got v=%b d=%h want 1/fffff00d", wb_valid_o, wb_data_o); end
        nxt();
    endtask

    task automatic test_reset_mid_op;
        drive_req(1'b1, 3'd2, 32'h700, 32'd0, 5'd3, 5'd30);
        nxt();
        idle_req();
        #1;
        vecs++; if (dmem_rmask_o !== 4'b1111) begin errs++; $display("FAIL rstmid_issue: got %b want 1111", dmem_rmask_o); end
        rst_i = 1'b1;
        #1;
        vecs++; if (dmem_rmask_o !== 4'b0000 || busy_o !== 1'b0 || req_ready_o !== 1'b1) begin
            errs++; $display("FAIL rstmid_abort: got m=%b busy=%b rdy=%b want 0000/0/1", dmem_rmask_o, busy_o, req_ready_o); end
        nxt();
        rst_i        = 1'b0;
        dmem_resp_i  = 1'b1;
        dmem_rdata_i = 32'h5555_5555;
        nxt();
        dmem_resp_i  = 1'b0;
        dmem_rdata_i = 32'd0;
        #1;
        vecs++; if (wb_valid_o !== 1'b0 || busy_o !== 1'b0) begin errs++; $display("FAIL rstmid_stray: got v=%b busy=%b want 0/0", wb_valid_o, busy_o); end
    endtask

    initial begin
        test_reset();
        test_lb_sign();
        test_stores();
        test_exceptions();
        test_full_in_order();
        test_flush_drain();
        test_flush_with_resp();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
